// File: rtl/rv32_dmem_pkg.sv
// rv32_dmem_pkg: shared constants and decode helper for the rv32 data-memory responder.
//   MMIO word offsets (aluout[3:2]), STATUS bit positions, address-decode enum,
//   and decode_addr() mapping a byte address to RAM / MMIO / UNMAPPED.
package rv32_dmem_pkg;

    localparam logic [1:0] CYCLE   = 2'd0;
    localparam logic [1:0] TX_DATA = 2'd1;
    localparam logic [1:0] STATUS  = 2'd2;
    localparam logic [1:0] TOHOST  = 2'd3;

    localparam int unsigned EMPTY     = 0;
    localparam int unsigned FULL      = 1;
    localparam int unsigned OVF       = 2;
    localparam int unsigned MISALIGN  = 3;
    localparam int unsigned COUNT_LSB = 4;

    typedef enum logic [1:0] {
        RAM,
        MMIO,
        UNMAPPED
    } dec_e;

    // MMIO is checked first so a base in the low segment still maps its 16-byte window
    function automatic dec_e decode_addr(input logic [31:0] addr, input logic [3:0] base_hi);
        if (addr[31:28] == base_hi && addr[27:4] == 24'd0) begin
            return MMIO;
        end else if (addr[31:28] == 4'd0) begin
            return RAM;
        end else begin
            return UNMAPPED;
        end
    endfunction

endpackage

// File: rtl/rv32_tx_fifo.sv
// rv32_tx_fifo: byte FIFO for the console TX path.
//   clk, reset (async, active-high)
//   push, push_data[7:0] : enqueue; accepted when not full, or when full with a pop this cycle
//   pop                  : dequeue head (ignored when empty)
//   head_data[7:0]       : byte at the head pointer
//   full, empty, count   : occupancy
module rv32_tx_fifo #(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    output logic [7:0]       head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt;
    logic             do_pop;
    logic             do_push;

    assign full      = (cnt == CNT_W'(DEPTH));
    assign empty     = (cnt == '0);
    assign count     = cnt;
    assign head_data = mem[head];

    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot the push lands in
    assign do_push = push && (!full || do_pop);

    // storage, pointers and occupancy; storage is cleared so an empty FIFO shows 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (do_push) begin
                mem[tail] <= push_data;
                tail      <= tail + PTR_W'(1);
            end
            if (do_pop) begin
                head <= head + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rv32_dmem.sv
// rv32_dmem_resp: data-memory responder for the rv32 core (single-cycle access model).
//   Word RAM at 0x0xxx_xxxx (wraps modulo RAM_WORDS); MMIO window at MMIO_BASE..+0xF:
//   CYCLE (ro counter), TX_DATA (wo FIFO push), STATUS, TOHOST.
//   clk, reset (async, active-high)
//   aluout[31:0], writedata[31:0], writesmem : core address, store data, store strobe
//   pause                                    : freezes the cycle counter
//   readdata[31:0]                           : combinational load data
//   tx_valid, tx_data[7:0], tx_ready         : console byte stream
//   tohost[31:0], halted                     : last TOHOST write, sticky nonzero-write flag
//   Optional RV32_DMEM_MISALIGN_TRAP_EN: suppress misaligned stores and flag them in STATUS[3].
module rv32_dmem_resp
    import rv32_dmem_pkg::*;
#(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    input  logic        writesmem,
    input  logic        pause,
    output logic [31:0] readdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [31:0] tohost,
    output logic        halted
);

    localparam int unsigned IDX_W = $clog2(RAM_WORDS);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]      ram [RAM_WORDS];
    dec_e             dec;
    logic [1:0]       off;
    logic [IDX_W-1:0] idx;
    logic             store;
    logic             mmio_wr;
    logic             status_wr;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_cnt;
    logic [3:0]       cnt_disp;
    logic             ovf_evt;
    logic [31:0]      cycle;
    logic             overflow;
    logic             misalign;
    logic [31:0]      status_word;

    assign dec = decode_addr(aluout, MMIO_BASE[31:28]);
    assign off = aluout[3:2];
    assign idx = aluout[IDX_W+1:2];

`ifdef RV32_DMEM_MISALIGN_TRAP_EN
    logic misalign_st;
    assign misalign_st = writesmem && (aluout[1:0] != 2'b00);
    assign store       = writesmem && !misalign_st;

    // sticky misaligned-store flag; cleared through STATUS bit 3
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign <= 1'b0;
        end else if (misalign_st) begin
            misalign <= 1'b1;
        end else if (status_wr && writedata[MISALIGN]) begin
            misalign <= 1'b0;
        end
    end
`else
    logic unused_lsbs;
    assign unused_lsbs = ^aluout[1:0];
    assign store       = writesmem;
    assign misalign    = 1'b0;
`endif

    assign mmio_wr   = store && (dec == MMIO);
    assign status_wr = mmio_wr && (off == STATUS);
    assign push      = mmio_wr && (off == TX_DATA);
    assign pop       = tx_valid && tx_ready;
    assign tx_valid  = !fifo_empty;
    // push dropped only when full and nothing leaves this cycle
    assign ovf_evt   = push && fifo_full && !pop;

    rv32_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (writedata[7:0]),
        .pop       (pop),
        .head_data (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    // RAM write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (store && dec == RAM) begin
            ram[idx] <= writedata;
        end
    end

    // cycle counter, overflow flag, tohost/halted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle    <= 32'd0;
            overflow <= 1'b0;
            tohost   <= 32'd0;
            halted   <= 1'b0;
        end else begin
            if (!pause) begin
                cycle <= cycle + 32'd1;
            end
            // a same-cycle overflow wins over a clear
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (status_wr && writedata[OVF]) begin
                overflow <= 1'b0;
            end
            if (mmio_wr && off == TOHOST) begin
                tohost <= writedata;
                if (writedata != 32'd0) begin
                    halted <= 1'b1;
                end
            end
        end
    end

    assign cnt_disp = (32'(fifo_cnt) > 32'd15) ? 4'hF : 4'(fifo_cnt);

    // STATUS word assembly
    always_comb begin
        status_word                   = 32'd0;
        status_word[EMPTY]            = fifo_empty;
        status_word[FULL]             = fifo_full;
        status_word[OVF]              = overflow;
        status_word[MISALIGN]         = misalign;
        status_word[COUNT_LSB +: 4]   = cnt_disp;
    end

    // combinational load mux
    always_comb begin
        readdata = 32'd0;
        case (dec)
            RAM:  readdata = ram[idx];
            MMIO: begin
                case (off)
                    CYCLE:   readdata = cycle;
                    STATUS:  readdata = status_word;
                    TOHOST:  readdata = tohost;
                    default: readdata = 32'd0;
                endcase
            end
            default: readdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_rv32_dmem_resp.sv
// tb_rv32_dmem_resp: directed + randomized bench for rv32_dmem_resp with a queue/array
// reference model; inputs change between edges, outputs compared 1 time unit later.
module tb_rv32_dmem_resp;

    localparam int unsigned RAM_WORDS  = 1024;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam logic [31:0] A_CYCLE  = 32'hF000_0000;
    localparam logic [31:0] A_TX     = 32'hF000_0004;
    localparam logic [31:0] A_STATUS = 32'hF000_0008;
    localparam logic [31:0] A_TOHOST = 32'hF000_000C;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic        writesmem;
    logic        pause;
    logic [31:0] readdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [31:0] tohost;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    rv32_dmem_resp #(
        .RAM_WORDS  (RAM_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .MMIO_BASE  (32'hF000_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .aluout    (aluout),
        .writedata (writedata),
        .writesmem (writesmem),
        .pause     (pause),
        .readdata  (readdata),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .tohost    (tohost),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // reference state
    logic [31:0]  m_ram   [RAM_WORDS];
    bit           m_known [RAM_WORDS];
    byte unsigned m_fifo  [$];
    byte unsigned got     [$];
    logic [31:0]  m_cycle;
    logic [31:0]  m_tohost;
    bit           m_halted;
    bit           m_ovf;
    bit           m_mis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_cycle  = 32'd0;
        m_tohost = 32'd0;
        m_halted = 1'b0;
        m_ovf    = 1'b0;
        m_mis    = 1'b0;
    endtask

    // 0 = RAM, 1 = MMIO, 2 = unmapped
    function automatic int region(input logic [31:0] a);
        if ((a >> 4) == 32'h0F00_0000) return 1;
        if (a < 32'h1000_0000) return 0;
        return 2;
    endfunction

    task automatic model_read(input logic [31:0] a, output bit ok, output logic [31:0] v);
        int unsigned idx;
        int          n;
        int          sat;
        ok  = 1'b1;
        v   = 32'd0;
        idx = (a / 4) % RAM_WORDS;
        n   = m_fifo.size();
        sat = (n > 15) ? 15 : n;
        case (region(a))
            0: begin
                ok = m_known[idx];
                v  = m_ram[idx];
            end
            1: begin
                case ((a / 4) % 4)
                    0: v = m_cycle;
                    2: v = 32'(sat * 16 + (m_mis ? 8 : 0) + (m_ovf ? 4 : 0)
                               + ((n == int'(FIFO_DEPTH)) ? 2 : 0) + ((n == 0) ? 1 : 0));
                    3: v = m_tohost;
                    default: v = 32'd0;
                endcase
            end
            default: v = 32'd0;
        endcase
    endtask

    // advance the model by one rising edge using the inputs currently applied
    task automatic model_step();
        bit          pop;
        bit          st;
        bit          mis_st;
        bit          ovf_evt;
        bit          clr_ovf;
        bit          clr_mis;
        int          r;
        int unsigned off;
        pop     = (m_fifo.size() != 0) && tx_ready;
        st      = writesmem;
        mis_st  = 1'b0;
        ovf_evt = 1'b0;
        clr_ovf = 1'b0;
        clr_mis = 1'b0;
`ifdef RV32_DMEM_MISALIGN_TRAP_EN
        if (writesmem && (aluout % 4) != 0) begin
            mis_st = 1'b1;
            st     = 1'b0;
        end
`endif
        r   = region(aluout);
        off = (aluout / 4) % 4;
        if (pop) void'(m_fifo.pop_front());
        if (st && r == 1) begin
            case (off)
                1: begin
                    if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(writedata[7:0]);
                    else ovf_evt = 1'b1;
                end
                2: begin
                    clr_ovf = writedata[2];
`ifdef RV32_DMEM_MISALIGN_TRAP_EN
                    clr_mis = writedata[3];
`endif
                end
                3: begin
                    m_tohost = writedata;
                    if (writedata != 0) m_halted = 1'b1;
                end
                default: ;
            endcase
        end
        if (st && r == 0) begin
            m_ram[(aluout / 4) % RAM_WORDS]   = writedata;
            m_known[(aluout / 4) % RAM_WORDS] = 1'b1;
        end
        if (!pause) m_cycle = m_cycle + 1;
        if (ovf_evt) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
        if (mis_st) m_mis = 1'b1;
        else if (clr_mis) m_mis = 1'b0;
    endtask

    task automatic check_all(input string tag);
        bit          ok;
        logic [31:0] v;
        #1;
        model_read(aluout, ok, v);
        if (ok) check({tag, ".rd"}, readdata, v);
        check({tag, ".valid"}, 32'(tx_valid), 32'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) check({tag, ".txd"}, 32'(tx_data), 32'(m_fifo[0]));
        check({tag, ".tohost"}, tohost, m_tohost);
        check({tag, ".halted"}, 32'(halted), 32'(m_halted));
    endtask

    task automatic tick();
        if (tx_valid && tx_ready) got.push_back(tx_data);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [31:0] a, input logic [31:0] wd, input logic we);
        aluout    = a;
        writedata = wd;
        writesmem = we;
        check_all(tag);
        tick();
    endtask

    // read with an additional fixed expectation
    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        aluout    = a;
        writedata = 32'd0;
        writesmem = 1'b0;
        check_all(tag);
        check({tag, ".const"}, readdata, exp);
        tick();
    endtask

    // asynchronous reset between edges, checked while asserted
    task automatic do_reset(input string tag);
        #2;
        reset     = 1'b1;
        aluout    = A_CYCLE;
        writesmem = 1'b0;
        #1;
        model_reset();
        check({tag, ".cycle"}, readdata, 32'd0);
        check({tag, ".valid"}, 32'(tx_valid), 32'd0);
        check({tag, ".txd"}, 32'(tx_data), 32'd0);
        check({tag, ".tohost"}, tohost, 32'd0);
        check({tag, ".halted"}, 32'(halted), 32'd0);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        logic        we;
        string       exp_str;

        reset     = 1'b1;
        aluout    = A_CYCLE;
        writedata = 32'd0;
        writesmem = 1'b0;
        pause     = 1'b0;
        tx_ready  = 1'b0;
        for (int i = 0; i < int'(RAM_WORDS); i++) m_known[i] = 1'b0;
        model_reset();
        #3;
        check("por.cycle", readdata, 32'd0);
        check("por.valid", 32'(tx_valid), 32'd0);
        check("por.txd", 32'(tx_data), 32'd0);
        check("por.halted", 32'(halted), 32'd0);
        #9;
        reset = 1'b0;

        // cycle counter: 10 running cycles then 5 paused
        for (int i = 0; i < 10; i++) cyc("cyc.run", A_CYCLE, 32'd0, 1'b0);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) peek("cyc.pause", A_CYCLE, 32'd10);
        cyc("cyc.wr_ignored", A_CYCLE, 32'h5555_5555, 1'b1);
        peek("cyc.after_wr", A_CYCLE, 32'd10);
        pause = 1'b0;
        for (int i = 0; i < 3; i++) cyc("cyc.run2", A_CYCLE, 32'd0, 1'b0);
        do_reset("rst_mid");

        // RAM write, next-cycle read, and wrap alias
        cyc("ram.wr", 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
        peek("ram.rd", 32'h0000_0010, 32'hDEAD_BEEF);
        peek("ram.wrap", 32'h0000_0010 + 32'(4 * RAM_WORDS), 32'hDEAD_BEEF);

        // TX with drain blocked: 9 pushes into depth 8
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) cyc("tx.push", A_TX, 32'(8'h41 + i), 1'b1);
        peek("tx.status_ovf", A_STATUS, 32'h86);
        cyc("tx.clr", A_STATUS, 32'h4, 1'b1);
        peek("tx.status_clr", A_STATUS, 32'h82);

        // full with drain: push accepted, no overflow
        got.delete();
        tx_ready = 1'b1;
        cyc("tx.push_full", A_TX, 32'h5A, 1'b1);
        peek("tx.status_full", A_STATUS, 32'h82);
        for (int i = 0; i < 20 && tx_valid; i++) cyc("tx.drain", A_STATUS, 32'd0, 1'b0);
        exp_str = "ABCDEFGHZ";
        check("tx.drain_len", 32'(got.size()), 32'(exp_str.len()));
        for (int i = 0; i < exp_str.len() && i < got.size(); i++)
            check("tx.drain_byte", 32'(got[i]), 32'(exp_str[i]));
        check("tx.valid_drop", 32'(tx_valid), 32'd0);
        peek("tx.status_empty", A_STATUS, 32'h01);

        // TOHOST / halted
        cyc("th.wr0", A_TOHOST, 32'd0, 1'b1);
        check("th.t0", tohost, 32'd0);
        check("th.h0", 32'(halted), 32'd0);
        cyc("th.wr1", A_TOHOST, 32'd1, 1'b1);
        check("th.t1", tohost, 32'd1);
        check("th.h1", 32'(halted), 32'd1);
        cyc("th.wr0b", A_TOHOST, 32'd0, 1'b1);
        check("th.t0b", tohost, 32'd0);
        check("th.h_sticky", 32'(halted), 32'd1);
        peek("th.rd", A_TOHOST, 32'd0);

        // unmapped read/write leaves state alone
        cyc("um.ram0", 32'h0000_0000, 32'h1111_1111, 1'b1);
        peek("um.rd", 32'h8000_0000, 32'd0);
        cyc("um.wr", 32'h8000_0000, 32'h1234_5678, 1'b1);
        cyc("um.wr_win", 32'hF000_0010, 32'h0000_0004, 1'b1);
        peek("um.ram0_chk", 32'h0000_0000, 32'h1111_1111);
        peek("um.tohost_chk", A_TOHOST, 32'd0);
        peek("um.status_chk", A_STATUS, 32'h01);

        // misaligned store
        cyc("mis.wr", 32'h0000_0011, 32'hCAFE_F00D, 1'b1);
`ifdef RV32_DMEM_MISALIGN_TRAP_EN
        peek("mis.ram", 32'h0000_0010, 32'hDEAD_BEEF);
        peek("mis.status", A_STATUS, 32'h09);
        cyc("mis.clr", A_STATUS, 32'h8, 1'b1);
        peek("mis.status_clr", A_STATUS, 32'h01);
`else
        peek("mis.ram", 32'h0000_0010, 32'hCAFE_F00D);
        peek("mis.status", A_STATUS, 32'h01);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            pause    = ($urandom_range(0, 3) == 0);
            tx_ready = 1'($urandom_range(0, 1));
            wd       = $urandom;
            we       = 1'b0;
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    a  = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 1) * 4 * RAM_WORDS);
                    we = 1'b1;
                end
                3, 4: a = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 1) * 4 * RAM_WORDS);
                5: begin
                    a  = A_TX;
                    we = 1'b1;
                end
                6: a = A_CYCLE + 32'($urandom_range(0, 3) * 4);
                7: begin
                    a  = A_STATUS;
                    we = 1'b1;
                end
                8: begin
                    a  = ($urandom_range(0, 1) == 0) ? 32'h1000_0000 + ($urandom & 32'h0FFF_FFFC)
                                                     : 32'hF000_0010 + ($urandom & 32'h00FF_FFF0);
                    we = 1'($urandom_range(0, 1));
                end
                default: begin
                    a  = A_TOHOST;
                    wd = 32'($urandom_range(0, 3));
                    we = 1'b1;
                end
            endcase
            cyc("rnd", a, wd, we);
        end

        do_reset("rst_end");
        #20;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
